fadd_issue_ctrl: RTL and testbench

FADD_ISSUE_CTRL -- requirements
Module: fadd_issue_ctrl

---
 rtl/fadd_issue_ctrl_if.sv | 30 +++
 rtl/fadd_issue_ctrl.sv | 131 +++++++++++++
 tb/tb_fadd_issue_ctrl.sv | 232 +++++++++++++++++++++++
 3 files changed

// File: rtl/fadd_issue_ctrl_if.sv
// Handshake and datapath bundle between a request producer, the fadd issue
// controller and the result consumer.
interface fadd_issue_ctrl_if #(
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic             in_sub;
    logic [31:0]      in_a;
    logic [31:0]      in_b;
    logic [TAG_W-1:0] in_tag;
    logic [31:0]      fadd_op1;
    logic [31:0]      fadd_op2;
    logic [31:0]      fadd_result;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_result;
    logic [TAG_W-1:0] out_tag;
    logic             busy;

    modport master (
        output in_valid, in_sub, in_a, in_b, in_tag, fadd_result, out_ready,
        input  in_ready, fadd_op1, fadd_op2, out_valid, out_result, out_tag, busy
    );

    modport slave (
        input  in_valid, in_sub, in_a, in_b, in_tag, fadd_result, out_ready,
        output in_ready, fadd_op1, fadd_op2, out_valid, out_result, out_tag, busy
    );
endinterface

// File: rtl/fadd_issue_ctrl.sv
// Issue controller for a fixed-latency fadd datapath: registers operands,
// tracks tags alongside the datapath, and buffers results in an in-order FIFO.
// Credit accounting (in flight + buffered < DEPTH) guarantees that a result
// leaving the pipe always finds room, so the datapath is never stalled.
module fadd_issue_ctrl #(
    parameter int DEPTH    = 8,
    parameter int FADD_LAT = 3,
    parameter int TAG_W    = 5
) (
    input  logic              clk,
    input  logic              reset,
    fadd_issue_ctrl_if.slave  bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int INF_W = $clog2(FADD_LAT + 2);
    localparam int SUM_W = ((CNT_W > INF_W) ? CNT_W : INF_W) + 1;

    logic [31:0]      op1_r;
    logic [31:0]      op2_r;
    logic [FADD_LAT:0] pipe_valid_r;
    logic [TAG_W-1:0] pipe_tag_r [FADD_LAT+1];
    logic [31:0]      res_mem_r [DEPTH];
    logic [TAG_W-1:0] tag_mem_r [DEPTH];
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] fifo_count_r;
    logic [CNT_W-1:0] fifo_count_next_s;
    logic [INF_W-1:0] inflight_r;
    logic [INF_W-1:0] inflight_next_s;
    logic [SUM_W-1:0] total_s;
    logic             in_ready_s;
    logic             out_valid_s;
    logic             accept_s;
    logic             push_s;
    logic             pop_s;

    // Outstanding work seen by the credit check; pops in this cycle earn no credit.
    assign total_s     = SUM_W'(inflight_r) + SUM_W'(fifo_count_r);
    assign in_ready_s  = !reset && (total_s < SUM_W'(DEPTH));
    assign out_valid_s = !reset && (fifo_count_r != CNT_W'(0));
    assign accept_s    = bus.in_valid && in_ready_s;
    assign push_s      = pipe_valid_r[FADD_LAT];
    assign pop_s       = out_valid_s && bus.out_ready;

    assign bus.in_ready   = in_ready_s;
    assign bus.out_valid  = out_valid_s;
    assign bus.out_result = res_mem_r[rd_ptr_r];
    assign bus.out_tag    = tag_mem_r[rd_ptr_r];
    assign bus.fadd_op1   = op1_r;
    assign bus.fadd_op2   = op2_r;
    assign bus.busy       = !reset && ((inflight_r != INF_W'(0)) || (fifo_count_r != CNT_W'(0)));

    // Operand register: subtraction is issued as an add with b's sign flipped.
    always_ff @(posedge clk) begin
        if (reset) begin
            op1_r <= 32'd0;
            op2_r <= 32'd0;
        end else if (accept_s) begin
            op1_r <= bus.in_a;
            op2_r <= {bus.in_b[31] ^ bus.in_sub, bus.in_b[30:0]};
        end else begin
            op1_r <= 32'd0;
            op2_r <= 32'd0;
        end
    end

    // Valid shift pipe mirroring the datapath: issue stage plus FADD_LAT stages.
    always_ff @(posedge clk) begin
        if (reset) begin
            pipe_valid_r <= '0;
        end else begin
            pipe_valid_r <= {pipe_valid_r[FADD_LAT-1:0], accept_s};
        end
    end

    // Tag shift pipe; tags are only meaningful where the matching valid is set.
    always_ff @(posedge clk) begin
        pipe_tag_r[0] <= bus.in_tag;
        for (int i = 1; i <= FADD_LAT; i++) begin
            pipe_tag_r[i] <= pipe_tag_r[i-1];
        end
    end

    // Result storage, written when a tracked result leaves the pipe.
    always_ff @(posedge clk) begin
        if (push_s) begin
            res_mem_r[wr_ptr_r] <= bus.fadd_result;
            tag_mem_r[wr_ptr_r] <= pipe_tag_r[FADD_LAT];
        end
    end

    // Next FIFO occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        fifo_count_next_s = fifo_count_r;
        case ({push_s, pop_s})
            2'b10:   fifo_count_next_s = fifo_count_r + CNT_W'(1);
            2'b01:   fifo_count_next_s = fifo_count_r - CNT_W'(1);
            default: fifo_count_next_s = fifo_count_r;
        endcase
    end

    // Next in-flight count: +1 on acceptance, -1 as a result enters the FIFO.
    always_comb begin
        inflight_next_s = inflight_r;
        case ({accept_s, push_s})
            2'b10:   inflight_next_s = inflight_r + INF_W'(1);
            2'b01:   inflight_next_s = inflight_r - INF_W'(1);
            default: inflight_next_s = inflight_r;
        endcase
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_r     <= '0;
            rd_ptr_r     <= '0;
            fifo_count_r <= '0;
            inflight_r   <= '0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end
            fifo_count_r <= fifo_count_next_s;
            inflight_r   <= inflight_next_s;
        end
    end
endmodule

// File: tb/tb_fadd_issue_ctrl.sv
// Self-checking bench for fadd_issue_ctrl: an emulated fadd datapath plus a
// transaction-level scoreboard predicting handshakes, latency and results.
module tb_fadd_issue_ctrl;
    localparam int DEPTH    = 8;
    localparam int FADD_LAT = 3;
    localparam int TAG_W    = 5;

    typedef struct {
        logic [31:0]      res;
        logic [TAG_W-1:0] tag;
        int               acc_edge;
    } ent_t;

    logic clk = 1'b0;
    logic reset;
    fadd_issue_ctrl_if #(.TAG_W(TAG_W)) bus();

    fadd_issue_ctrl #(.DEPTH(DEPTH), .FADD_LAT(FADD_LAT), .TAG_W(TAG_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          edge_n   = 0;
    ent_t        sb[$];
    logic [31:0] exp_op1;
    logic [31:0] exp_op2;
    bit          ops_known = 1'b0;
    int          dut_acc_n = 0;
    int          dut_pop_n = 0;
    int          dut_ov_n  = 0;
    int          pop_first = -1;
    int          pop_last  = -1;
    logic [31:0] last_res;
    logic [TAG_W-1:0] last_tag;
    logic [31:0] dp_r [FADD_LAT];

    function automatic logic [63:0] s2d(input logic [31:0] s);
        logic [10:0] e;
        if (s[30:0] == 31'd0) return {s[31], 63'd0};
        e = {3'b000, s[30:23]} + 11'd896;
        return {s[31], e, s[22:0], 29'd0};
    endfunction

    function automatic logic [31:0] d2s(input logic [63:0] d);
        logic [10:0] e;
        if (d[62:0] == 63'd0) return {d[63], 31'd0};
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] int_bits(input int k);
        return d2s($realtobits(real'(k)));
    endfunction

    // Arithmetic meaning of a request: a+b or a-b, in real numbers.
    function automatic logic [31:0] ref_result(input logic [31:0] a, input logic [31:0] b, input bit sub);
        real ra;
        real rb;
        ra = $bitstoreal(s2d(a));
        rb = $bitstoreal(s2d(b));
        return d2s($realtobits(sub ? (ra - rb) : (ra + rb)));
    endfunction

    // Emulated fadd datapath: FADD_LAT-stage adder of the issued operands.
    always @(posedge clk) begin
        dp_r[0] <= d2s($realtobits($bitstoreal(s2d(bus.fadd_op1)) + $bitstoreal(s2d(bus.fadd_op2))));
        for (int i = 1; i < FADD_LAT; i++) dp_r[i] <= dp_r[i-1];
    end
    assign bus.fadd_result = dp_r[FADD_LAT-1];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the scoreboard, advance the model.
    task automatic run_cycle(input bit rst, input bit v, input bit sub, input logic [31:0] a,
                             input logic [31:0] b, input logic [TAG_W-1:0] tg, input bit ordy,
                             output bit acc);
        bit   exp_rdy;
        bit   exp_ov;
        bit   exp_busy;
        bit   pop;
        ent_t e;
        reset         = rst;
        bus.in_valid  = v;
        bus.in_sub    = sub;
        bus.in_a      = a;
        bus.in_b      = b;
        bus.in_tag    = tg;
        bus.out_ready = ordy;
        #1;
        exp_rdy  = !rst && (sb.size() < DEPTH);
        exp_ov   = !rst && (sb.size() != 0) && (sb[0].acc_edge + FADD_LAT + 1 <= edge_n);
        exp_busy = !rst && (sb.size() != 0);
        check("in_ready", 64'(bus.in_ready), 64'(exp_rdy));
        check("out_valid", 64'(bus.out_valid), 64'(exp_ov));
        check("busy", 64'(bus.busy), 64'(exp_busy));
        if (ops_known) begin
            check("fadd_op1", 64'(bus.fadd_op1), 64'(exp_op1));
            check("fadd_op2", 64'(bus.fadd_op2), 64'(exp_op2));
        end
        if (exp_ov) begin
            check("out_result", 64'(bus.out_result), 64'(sb[0].res));
            check("out_tag", 64'(bus.out_tag), 64'(sb[0].tag));
        end
        if (bus.in_valid && bus.in_ready) dut_acc_n++;
        if (bus.out_valid) dut_ov_n++;
        if (bus.out_valid && bus.out_ready) begin
            dut_pop_n++;
            if (pop_first < 0) pop_first = edge_n;
            pop_last = edge_n;
            last_res = bus.out_result;
            last_tag = bus.out_tag;
        end
        acc = v && exp_rdy;
        pop = exp_ov && ordy;
        @(posedge clk);
        edge_n++;
        if (rst) begin
            sb.delete();
            exp_op1 = 32'd0;
            exp_op2 = 32'd0;
        end else begin
            if (pop) void'(sb.pop_front());
            if (acc) begin
                e.res      = ref_result(a, b, sub);
                e.tag      = tg;
                e.acc_edge = edge_n;
                sb.push_back(e);
                exp_op1 = a;
                exp_op2 = sub ? {~b[31], b[30:0]} : b;
            end else begin
                exp_op1 = 32'd0;
                exp_op2 = 32'd0;
            end
        end
        ops_known = 1'b1;
        @(negedge clk);
    endtask

    task automatic idle(input int n, input bit ordy);
        bit acc;
        for (int i = 0; i < n; i++) run_cycle(1'b0, 1'b0, 1'b0, 32'd0, 32'd0, '0, ordy, acc);
    endtask

    initial begin
        bit acc;
        int k;
        int base;
        reset = 1'b1;
        bus.in_valid = 1'b0; bus.in_sub = 1'b0; bus.in_a = 32'd0; bus.in_b = 32'd0;
        bus.in_tag = '0; bus.out_ready = 1'b0;
        @(negedge clk);

        // Reset state, then first cycle out of reset.
        for (int i = 0; i < 3; i++) run_cycle(1'b1, 1'b1, 1'b0, 32'd0, 32'd0, '0, 1'b0, acc);
        idle(1, 1'b0);

        // Add: 1.0 + 2.0, tag 3.
        run_cycle(1'b0, 1'b1, 1'b0, 32'h3F800000, 32'h40000000, TAG_W'(3), 1'b1, acc);
        idle(7, 1'b1);
        check("add_result", 64'(last_res), 64'h40400000);
        check("add_tag", 64'(last_tag), 64'd3);

        // Subtract: 3.0 - 1.0.
        run_cycle(1'b0, 1'b1, 1'b1, 32'h40400000, 32'h3F800000, TAG_W'(4), 1'b1, acc);
        idle(7, 1'b1);
        check("sub_result", 64'(last_res), 64'h40000000);

        // Backpressure: tags 0..9 offered with the consumer stalled.
        k = 0;
        base = dut_acc_n;
        for (int i = 0; i < 14; i++) begin
            run_cycle(1'b0, 1'b1, 1'b0, int_bits(k + 1), int_bits(10), TAG_W'(k), 1'b0, acc);
            if (acc) k++;
        end
        check("bp_accepted", 64'(dut_acc_n - base), 64'd8);
        for (int i = 0; i < 30; i++) begin
            run_cycle(1'b0, k < 10, 1'b0, int_bits(k + 1), int_bits(10), TAG_W'(k), 1'b1, acc);
            if (acc) k++;
        end
        check("bp_resumed", 64'(dut_acc_n - base), 64'd10);
        idle(8, 1'b1);

        // Throughput: 16 back-to-back requests with the consumer always ready.
        base = dut_acc_n;
        dut_pop_n = 0; pop_first = -1; pop_last = -1;
        for (int i = 0; i < 16; i++)
            run_cycle(1'b0, 1'b1, 1'b0, int_bits(i), int_bits(100), TAG_W'(i), 1'b1, acc);
        idle(10, 1'b1);
        check("tput_accepted", 64'(dut_acc_n - base), 64'd16);
        check("tput_pops", 64'(dut_pop_n), 64'd16);
        check("tput_span", 64'(pop_last - pop_first + 1), 64'd16);

        // Fill to 8 buffered results, then push and pop together at high occupancy.
        for (int i = 0; i < 14; i++)
            run_cycle(1'b0, 1'b1, 1'b1, int_bits(i), int_bits(7), TAG_W'(i + 8), 1'b0, acc);
        for (int i = 0; i < 24; i++)
            run_cycle(1'b0, 1'b1, 1'b0, int_bits(-i), int_bits(3), TAG_W'(i), 1'b1, acc);
        idle(10, 1'b1);

        // Reset mid-operation: 3 acceptances, 2 cycles, reset; nothing stale may appear.
        for (int i = 0; i < 3; i++)
            run_cycle(1'b0, 1'b1, 1'b0, int_bits(i), int_bits(5), TAG_W'(i), 1'b1, acc);
        idle(2, 1'b1);
        run_cycle(1'b1, 1'b0, 1'b0, 32'd0, 32'd0, '0, 1'b1, acc);
        dut_ov_n = 0;
        idle(10, 1'b1);
        check("rst_no_stale", 64'(dut_ov_n), 64'd0);

        // Randomized traffic with occasional reset.
        for (int i = 0; i < 800; i++) begin
            run_cycle($urandom_range(0, 99) == 0, $urandom_range(0, 9) < 7, 1'($urandom_range(0, 1)),
                      int_bits(int'($urandom_range(0, 2000)) - 1000),
                      int_bits(int'($urandom_range(0, 2000)) - 1000),
                      TAG_W'($urandom), $urandom_range(0, 9) < 6, acc);
        end
        idle(12, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
